// File: rtl/core_pkg.sv
// Shared types and constants for the multi-cycle core sequencer.
package core_pkg;

  typedef enum logic [2:0] {
    ST_START,
    ST_FETCH,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  function automatic bit xlen_legal(input int unsigned xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/core_seq_timeout.sv
// Bus wait-cycle counter; flags expiry when a request is still unanswered in the limit cycle.
module core_seq_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic ready,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_limit;

  // Requests are always separated by a request-free cycle, so clearing while
  // idle is the same as clearing on entry to a bus state.
  always_comb begin
    at_limit = (cnt_q == LIMIT);
    cnt_d    = cnt_q;
    if (!req) begin
      cnt_d = '0;
    end else if (!ready && !at_limit) begin
      cnt_d = cnt_q + CW'(1);
    end
    expire = req & ~ready & at_limit;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/core_mc_seq.sv
// Multi-cycle FETCH/EXEC/MEM/WB sequencer over a shared request/ready bus.
// Optional bus timeout with HALT state enabled by defining CORE_BUS_TIMEOUT_EN.
module core_mc_seq
  import core_pkg::*;
#(
  parameter int unsigned     XLEN           = 32,
  parameter logic [XLEN-1:0] RESET_PC       = '0,
  parameter int unsigned     TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  output logic              bus_req,
  output logic              bus_we,
  output logic [XLEN-1:0]   bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  output logic [XLEN/8-1:0] bus_be,
  input  logic              bus_ready,
  input  logic [XLEN-1:0]   bus_rdata,
  output logic              bus_err,
  input  logic              dec_mem_rd,
  input  logic              dec_mem_wr,
  input  logic              dec_reg_wen,
  input  logic              take_branch,
  input  logic [XLEN-1:0]   branch_target,
  input  logic [XLEN-1:0]   mem_addr,
  input  logic [XLEN-1:0]   mem_wrdata,
  input  logic [XLEN/8-1:0] mem_be,
  output logic [31:0]       inst,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   mem_rddata,
  output logic              reg_file_wen,
  output logic              pc_wren,
  output logic [XLEN-1:0]   instret
);

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $error("core_mc_seq: XLEN must be 32 or 64");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("core_mc_seq: TIMEOUT_CYCLES must be at least 1");
  end

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [31:0]       inst_q, inst_d;
  logic [XLEN-1:0]   rddata_q, rddata_d;
  logic [XLEN-1:0]   instret_q, instret_d;
  logic              err_q, err_d;
  logic [31:0]       fetch_word;
  logic              expire;

  if (XLEN == 64) begin : g_fetch64
    assign fetch_word = pc_q[2] ? bus_rdata[63:32] : bus_rdata[31:0];
  end else begin : g_fetch32
    assign fetch_word = bus_rdata[31:0];
  end

`ifdef CORE_BUS_TIMEOUT_EN
  core_seq_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .req   (bus_req),
    .ready (bus_ready),
    .expire(expire)
  );
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    rddata_d     = rddata_q;
    instret_d    = instret_q;
    err_d        = err_q;
    bus_req      = 1'b0;
    bus_we       = 1'b0;
    bus_addr     = '0;
    bus_wdata    = '0;
    bus_be       = '0;
    reg_file_wen = 1'b0;
    pc_wren      = 1'b0;

    case (state_q)
      ST_START: state_d = ST_FETCH;
      ST_FETCH: begin
        bus_req  = 1'b1;
        bus_addr = pc_q;
        bus_be   = '1;
        if (bus_ready) begin
          inst_d  = fetch_word;
          state_d = ST_EXEC;
        end else if (expire) begin
          err_d   = 1'b1;
          state_d = ST_HALT;
        end
      end
      ST_EXEC: state_d = (dec_mem_rd || dec_mem_wr) ? ST_MEM : ST_WB;
      ST_MEM: begin
        bus_req   = 1'b1;
        bus_we    = dec_mem_wr;
        bus_addr  = mem_addr;
        bus_wdata = mem_wrdata;
        bus_be    = mem_be;
        if (bus_ready) begin
          // A decode with both read and write set is a store: no load capture.
          if (!dec_mem_wr) rddata_d = bus_rdata;
          state_d = ST_WB;
        end else if (expire) begin
          err_d   = 1'b1;
          state_d = ST_HALT;
        end
      end
      ST_WB: begin
        reg_file_wen = dec_reg_wen;
        pc_wren      = 1'b1;
        pc_d         = take_branch ? {branch_target[XLEN-1:2], 2'b00} : pc_q + XLEN'(4);
        instret_d    = instret_q + XLEN'(1);
        state_d      = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_START;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_START;
      pc_q      <= RESET_PC;
      inst_q    <= NOP_INST;
      rddata_q  <= '0;
      instret_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      rddata_q  <= rddata_d;
      instret_q <= instret_d;
      err_q     <= err_d;
    end
  end

  assign inst       = inst_q;
  assign pc         = pc_q;
  assign mem_rddata = rddata_q;
  assign instret    = instret_q;
  assign bus_err    = err_q;

endmodule

// File: tb/tb_core_mc_seq.sv
// Scoreboard bench for core_mc_seq: bus transactions and write-back events are queued as stimulus is issued.
module tb_core_mc_seq;

  logic        clk;
  logic        rst;
  logic        bus_req, bus_we, bus_ready, bus_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        dec_mem_rd, dec_mem_wr, dec_reg_wen, take_branch;
  logic [31:0] branch_target, mem_addr, mem_wrdata;
  logic [3:0]  mem_be;
  logic [31:0] inst, pc, mem_rddata, instret;
  logic        reg_file_wen, pc_wren;

  logic        r64, req64, we64, rdy64, err64, rfw64, pcw64;
  logic [63:0] addr64, wdata64, rdata64, pc64, rdd64, ir64, zero64;
  logic [7:0]  be64, zbe64;
  logic [31:0] inst64;
  logic        zbit;

  core_mc_seq #(.XLEN(32), .RESET_PC(32'h0), .TIMEOUT_CYCLES(4)) u_dut (
    .clk(clk), .rst(rst), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
    .bus_err(bus_err), .dec_mem_rd(dec_mem_rd), .dec_mem_wr(dec_mem_wr),
    .dec_reg_wen(dec_reg_wen), .take_branch(take_branch), .branch_target(branch_target),
    .mem_addr(mem_addr), .mem_wrdata(mem_wrdata), .mem_be(mem_be), .inst(inst), .pc(pc),
    .mem_rddata(mem_rddata), .reg_file_wen(reg_file_wen), .pc_wren(pc_wren), .instret(instret)
  );

  core_mc_seq #(.XLEN(64), .RESET_PC(64'h0), .TIMEOUT_CYCLES(4)) u_dut64 (
    .clk(clk), .rst(r64), .bus_req(req64), .bus_we(we64), .bus_addr(addr64),
    .bus_wdata(wdata64), .bus_be(be64), .bus_ready(rdy64), .bus_rdata(rdata64),
    .bus_err(err64), .dec_mem_rd(zbit), .dec_mem_wr(zbit), .dec_reg_wen(zbit),
    .take_branch(zbit), .branch_target(zero64), .mem_addr(zero64), .mem_wrdata(zero64),
    .mem_be(zbe64), .inst(inst64), .pc(pc64), .mem_rddata(rdd64), .reg_file_wen(rfw64),
    .pc_wren(pcw64), .instret(ir64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit rd, wr, rwen, br;
    logic [31:0] target, maddr, wdata;
    logic [3:0] be;
    int unsigned fw, mw;
    logic [31:0] iword, ld;
  } instr_t;

  typedef struct {
    bit is_fetch, we;
    logic [31:0] addr, wdata;
    logic [3:0] be;
    bit chk_wdata;
    int unsigned waits;
    logic [31:0] rdata;
  } bus_txn_t;

  typedef struct {
    bit reg_wen;
    logic [31:0] inst, rddata, pc_cur;
    int unsigned lat;
  } wb_exp_t;

  localparam int unsigned NPROG = 10;
  instr_t      prog [NPROG];
  bus_txn_t    bus_q[$];
  wb_exp_t     wb_q[$];
  int unsigned n_checks, n_errors;
  int unsigned wait_cnt, lat;
  bit          started, done, aborted;
  logic [31:0] m_pc, m_instret, m_rddata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load_instr(input int unsigned i);
    instr_t      p;
    bit          mem;
    logic [31:0] nxt;
    p             = prog[i];
    dec_mem_rd    = p.rd;
    dec_mem_wr    = p.wr;
    dec_reg_wen   = p.rwen;
    take_branch   = p.br;
    branch_target = p.target;
    mem_addr      = p.maddr;
    mem_wrdata    = p.wdata;
    mem_be        = p.be;
    mem           = p.rd | p.wr;
    bus_q.push_back(bus_txn_t'{1'b1, 1'b0, m_pc, 32'h0, 4'hF, 1'b0, p.fw, p.iword});
    if (mem)
      bus_q.push_back(bus_txn_t'{1'b0, p.wr, p.maddr, p.wdata, p.be, p.wr, p.mw,
                                 p.wr ? 32'hBAD0_BAD0 : p.ld});
    if (mem && !p.wr) m_rddata = p.ld;
    nxt = p.br ? {p.target[31:2], 2'b00} : m_pc + 32'd4;
    wb_q.push_back(wb_exp_t'{p.rwen, p.iword, m_rddata, m_pc,
                             3 + (mem ? 1 : 0) + p.fw + (mem ? p.mw : 0)});
    m_pc      = nxt;
    m_instret = m_instret + 32'd1;
    started   = 1'b0;
    wait_cnt  = 0;
  endtask

  // Called once per negedge: plays the bus slave and scores write-back.
  task automatic service();
    bus_txn_t t;
    wb_exp_t  w;
    string    tag;
    if (started) lat++;
    if (bus_req) begin
      if (!started) begin
        started = 1'b1;
        lat     = 1;
      end
      if (bus_q.size() == 0) begin
        check("unexpected_req", 64'(bus_req), 64'(1'b0));
        bus_ready = 1'b0;
      end else begin
        t   = bus_q[0];
        tag = t.is_fetch ? "fetch_addr" : "mem_addr";
        check(tag, 64'(bus_addr), 64'(t.addr));
        check("bus_we", 64'(bus_we), 64'(t.we));
        check("bus_be", 64'(bus_be), 64'(t.be));
        if (t.chk_wdata) check("bus_wdata", 64'(bus_wdata), 64'(t.wdata));
        if (wait_cnt == t.waits) begin
          bus_ready = 1'b1;
          bus_rdata = t.rdata;
          void'(bus_q.pop_front());
          wait_cnt = 0;
        end else begin
          bus_ready = 1'b0;
          bus_rdata = $urandom;
          wait_cnt++;
        end
      end
    end else begin
      bus_ready = 1'($urandom_range(0, 1));
      bus_rdata = $urandom;
    end
    if (pc_wren) begin
      if (wb_q.size() == 0) begin
        check("unexpected_wb", 64'(pc_wren), 64'(1'b0));
      end else begin
        w = wb_q.pop_front();
        check("reg_file_wen", 64'(reg_file_wen), 64'(w.reg_wen));
        check("inst", 64'(inst), 64'(w.inst));
        check("mem_rddata", 64'(mem_rddata), 64'(w.rddata));
        check("pc_hold", 64'(pc), 64'(w.pc_cur));
        check("latency", 64'(lat), 64'(w.lat));
        check("bus_q_drained", 64'(bus_q.size()), 64'(0));
      end
      done = 1'b1;
    end else if (reg_file_wen) begin
      check("stray_reg_wen", 64'(reg_file_wen), 64'(1'b0));
    end
  endtask

  task automatic post_wb();
    check("pc", 64'(pc), 64'(m_pc));
    check("instret", 64'(instret), 64'(m_instret));
  endtask

  initial begin
    n_checks = 0; n_errors = 0; aborted = 1'b0;
    rst = 1'b0; r64 = 1'b0; bus_ready = 1'b0; bus_rdata = '0;
    dec_mem_rd = 0; dec_mem_wr = 0; dec_reg_wen = 0; take_branch = 0;
    branch_target = '0; mem_addr = '0; mem_wrdata = '0; mem_be = '0;
    rdy64 = 1'b1; rdata64 = {32'h1111_1111, 32'h2222_2222};
    zero64 = '0; zbe64 = '0; zbit = 1'b0;
    m_pc = 32'h0; m_instret = 32'h0; m_rddata = 32'h0;

    prog[0] = instr_t'{0, 0, 1, 0, 32'h0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0010_0093, 32'h0};
    prog[1] = instr_t'{1, 0, 1, 0, 32'h0, 32'h100, 32'h0, 4'hF, 0, 2, 32'h1000_2103, 32'hDEAD_BEEF};
    prog[2] = instr_t'{0, 1, 0, 0, 32'h0, 32'h104, 32'h1234_5678, 4'b0011, 1, 0, 32'h0020_9223, 32'h0};
    prog[3] = instr_t'{0, 0, 0, 1, 32'h203, 32'h0, 32'h0, 4'h0, 0, 0, 32'h1E00_0063, 32'h0};
    prog[4] = instr_t'{0, 0, 1, 0, 32'h0, 32'h0, 32'h0, 4'h0, 3, 0, 32'h0020_8233, 32'h0};
    prog[5] = instr_t'{1, 1, 0, 0, 32'h0, 32'h300, 32'hCAFE_F00D, 4'b1100, 0, 1, 32'h0031_2023, 32'h5555_5555};
    prog[6] = instr_t'{1, 0, 1, 0, 32'h0, 32'h104, 32'h0, 4'hF, 0, 0, 32'h1040_2183, 32'h0F0F_0F0F};
    prog[7] = instr_t'{0, 0, 1, 1, 32'hFFFF_FFFE, 32'h0, 32'h0, 4'h0, 0, 0, 32'hFFDF_F0EF, 32'h0};
    prog[8] = instr_t'{0, 0, 1, 0, 32'h0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h0000_0013, 32'h0};
    prog[9] = instr_t'{0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0050_0293, 32'h0};

    repeat (2) @(negedge clk);
    check("rst_pc", 64'(pc), 64'(32'h0));
    check("rst_inst", 64'(inst), 64'(32'h0000_0013));
    check("rst_mem_rddata", 64'(mem_rddata), 64'(32'h0));
    check("rst_instret", 64'(instret), 64'(32'h0));
    check("rst_bus_err", 64'(bus_err), 64'(1'b0));
    check("rst_bus_req", 64'(bus_req), 64'(1'b0));
    check("rst_reg_file_wen", 64'(reg_file_wen), 64'(1'b0));
    check("rst_pc_wren", 64'(pc_wren), 64'(1'b0));
    check("rst_bus_addr", 64'(bus_addr), 64'(32'h0));
    check("rst_bus_wdata", 64'(bus_wdata), 64'(32'h0));
    check("rst_bus_be", 64'(bus_be), 64'(4'h0));
    rst = 1'b1;

    for (int unsigned i = 0; i < NPROG; i++) begin
      if (i > 0) post_wb();
      load_instr(i);
      if (i == 0) check("start_no_req", 64'(bus_req), 64'(1'b0));
      done = 1'b0;
      for (int c = 0; c < 64; c++) begin
        service();
        if (done) break;
        @(negedge clk);
      end
      if (!done) begin
        check("wb_reached", 64'(done), 64'(1'b1));
        aborted = 1'b1;
        break;
      end
      @(negedge clk);
    end

    if (!aborted) begin
      post_wb();
      bus_ready = 1'b0;
      check("refetch_req", 64'(bus_req), 64'(1'b1));
      check("refetch_addr", 64'(bus_addr), 64'(m_pc));
      #2 rst = 1'b0;
      #1;
      check("async_req_drop", 64'(bus_req), 64'(1'b0));
      check("async_addr_clear", 64'(bus_addr), 64'(32'h0));
    end
    rst = 1'b0;

    @(negedge clk);
    r64 = 1'b1;
    @(negedge clk);
    check("x64_fetch0_req", 64'(req64), 64'(1'b1));
    check("x64_fetch0_addr", addr64, 64'h0);
    check("x64_fetch0_be", 64'(be64), 64'(8'hFF));
    @(negedge clk);
    check("x64_inst_lo", 64'(inst64), 64'(32'h2222_2222));
    @(negedge clk);
    check("x64_wb", 64'(pcw64), 64'(1'b1));
    @(negedge clk);
    check("x64_fetch1_addr", addr64, 64'h4);
    @(negedge clk);
    check("x64_inst_hi", 64'(inst64), 64'(32'h1111_1111));
    check("x64_instret", ir64, 64'h1);

`ifdef CORE_BUS_TIMEOUT_EN
    begin
      int unsigned n_req;
      n_req     = 0;
      bus_ready = 1'b0;
      dec_mem_rd = 0; dec_mem_wr = 0; take_branch = 0;
      @(negedge clk);
      rst = 1'b1;
      repeat (12) begin
        @(negedge clk);
        if (bus_req) n_req++;
      end
      check("to_req_cycles", 64'(n_req), 64'(5));
      check("to_bus_req", 64'(bus_req), 64'(1'b0));
      check("to_bus_err", 64'(bus_err), 64'(1'b1));
      check("to_pc_wren", 64'(pc_wren), 64'(1'b0));
      check("to_pc", 64'(pc), 64'(32'h0));
      #2 rst = 1'b0;
      #1;
      check("to_err_cleared", 64'(bus_err), 64'(1'b0));
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
